// File: rtl/stego_extract_decrypt_pkg.sv
// Shared types and defaults for the LSB steganography receive path.
package stego_extract_decrypt_pkg;

    typedef enum logic [1:0] {IDLE, COLLECT, DONE} state_t;

    localparam int NIB_W       = 4;
    localparam int DEF_NUM_KEY = 208;
    localparam int DEF_LEN_W   = 16;
    localparam int DEF_KADDR_W = 8;

    function automatic logic [NIB_W-1:0] unmask(input logic [NIB_W-1:0] cipher,
                                               input logic [NIB_W-1:0] key);
        return cipher ^ key;
    endfunction

endpackage

// File: rtl/stego_extract_decrypt_if.sv
// Stego byte input stream and plaintext nibble output stream.
interface stego_extract_decrypt_if;

    logic                                     pix_valid;
    logic                                     pix_ready;
    logic [7:0]                               pix_data;
    logic                                     nib_valid;
    logic                                     nib_ready;
    logic [stego_extract_decrypt_pkg::NIB_W-1:0] nib_data;

    modport master (output pix_valid, pix_data, nib_ready,
                    input  pix_ready, nib_valid, nib_data);
    modport slave  (input  pix_valid, pix_data, nib_ready,
                    output pix_ready, nib_valid, nib_data);

endinterface

// File: rtl/stego_extract_decrypt_key_ring.sv
// Key nibble register file with a read pointer that wraps at NUM_KEY.
module stego_extract_decrypt_key_ring
    import stego_extract_decrypt_pkg::*;
#(
    parameter int NUM_KEY = DEF_NUM_KEY,
    parameter int KADDR_W = DEF_KADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [KADDR_W-1:0] wr_addr,
    input  logic [NIB_W-1:0]   wr_data,
    input  logic               advance,
    input  logic               clear,
    output logic [NIB_W-1:0]   rd_data
);

    localparam int SLOTS = 2 ** KADDR_W;
    localparam int LIM_W = KADDR_W + 1;
    localparam logic [LIM_W-1:0]   KEY_LIM  = LIM_W'(NUM_KEY);
    localparam logic [KADDR_W-1:0] LAST_IDX = KADDR_W'(NUM_KEY - 1);

    // Sized to the full address space so the pointer indexes without truncation;
    // slots at or above NUM_KEY are never written and never reached by the pointer.
    logic [NIB_W-1:0]   slots [SLOTS];
    logic [KADDR_W-1:0] idx;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SLOTS; i++) slots[i] <= '0;
            idx <= '0;
        end else begin
            if (wr_en && ({1'b0, wr_addr} < KEY_LIM)) slots[wr_addr] <= wr_data;
            if (clear)
                idx <= '0;
            else if (advance)
                idx <= (idx == LAST_IDX) ? '0 : idx + KADDR_W'(1);
        end
    end

    assign rd_data = slots[idx];

endmodule

// File: rtl/stego_extract_decrypt.sv
// Extracts LSB message bits from stego bytes, packs nibbles LSB-first and
// decrypts each with a repeating key nibble.
module stego_extract_decrypt
    import stego_extract_decrypt_pkg::*;
#(
    parameter int NUM_KEY = DEF_NUM_KEY,
    parameter int LEN_W   = DEF_LEN_W,
    parameter int KADDR_W = DEF_KADDR_W
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [LEN_W-1:0]    msg_nibbles,
    input  logic                key_wr_en,
    input  logic [KADDR_W-1:0]  key_wr_addr,
    input  logic [NIB_W-1:0]    key_wr_data,
    stego_extract_decrypt_if.slave bus,
    output logic                busy,
    output logic                done
);

    state_t           state, state_nx;
    logic [1:0]       bit_cnt;
    logic [2:0]       shift;
    logic [LEN_W-1:0] to_collect;
    logic [LEN_W-1:0] to_emit;
    logic [NIB_W-1:0] key_nib;
    logic             go, accept, fourth, handoff;
    logic             unused_pix;

    assign unused_pix = ^bus.pix_data[7:1];
    assign go         = start && (state != COLLECT);
    assign handoff    = bus.nib_valid && bus.nib_ready;
    // Hold off the 4th bit while the previous nibble is still stuck in the output register.
    assign bus.pix_ready = (state == COLLECT)
                         && !(bit_cnt == 2'd3 && bus.nib_valid && !bus.nib_ready)
                         && (to_collect != '0);
    assign accept     = bus.pix_valid && bus.pix_ready;
    assign fourth     = accept && (bit_cnt == 2'd3);

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_nx = (msg_nibbles == '0) ? DONE : COLLECT;
            end
            COLLECT: begin
                busy = 1'b1;
                if (handoff && to_emit == LEN_W'(1)) state_nx = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (start) state_nx = (msg_nibbles == '0) ? DONE : COLLECT;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            bit_cnt       <= '0;
            shift         <= '0;
            to_collect    <= '0;
            to_emit       <= '0;
            bus.nib_valid <= 1'b0;
            bus.nib_data  <= '0;
        end else begin
            state <= state_nx;
            if (go) begin
                bit_cnt    <= '0;
                to_collect <= msg_nibbles;
                to_emit    <= msg_nibbles;
            end else begin
                if (accept) begin
                    bit_cnt <= bit_cnt + 2'd1;
                    case (bit_cnt)
                        2'd0:    shift[0] <= bus.pix_data[0];
                        2'd1:    shift[1] <= bus.pix_data[0];
                        2'd2:    shift[2] <= bus.pix_data[0];
                        default: ;
                    endcase
                end
                // A fresh nibble wins over a same-edge handoff, keeping nib_valid high.
                if (fourth) begin
                    bus.nib_data  <= unmask({bus.pix_data[0], shift}, key_nib);
                    bus.nib_valid <= 1'b1;
                    to_collect    <= to_collect - LEN_W'(1);
                end else if (handoff) begin
                    bus.nib_valid <= 1'b0;
                end
                if (handoff) to_emit <= to_emit - LEN_W'(1);
            end
        end
    end

    stego_extract_decrypt_key_ring #(
        .NUM_KEY (NUM_KEY),
        .KADDR_W (KADDR_W)
    ) u_key_ring (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (key_wr_en && (state != COLLECT)),
        .wr_addr (key_wr_addr),
        .wr_data (key_wr_data),
        .advance (fourth),
        .clear   (go),
        .rd_data (key_nib)
    );

endmodule
